// File: rtl/interfaz_tx_if.sv
// ALU-result / UART-TX handshake bundle for the interfaz_tx stage.
// The slave side is the interfaz_tx block itself; the master side is its environment
// (ALU strobe source plus UART transmitter).
interface interfaz_tx_if #(
    parameter int NB_DATA = 8
);
    logic [NB_DATA-1:0] i_resultado;
    logic               i_alu_valid;
    logic               i_tx_done;
    logic               o_tx_start;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_busy;
    logic               o_full;
    logic               o_overflow;

    modport slave (
        input  i_resultado,
        input  i_alu_valid,
        input  i_tx_done,
        output o_tx_start,
        output o_tx_data,
        output o_busy,
        output o_full,
        output o_overflow
    );

    modport master (
        output i_resultado,
        output i_alu_valid,
        output i_tx_done,
        input  o_tx_start,
        input  o_tx_data,
        input  o_busy,
        input  o_full,
        input  o_overflow
    );
endinterface

// File: rtl/interfaz_tx.sv
// interfaz_tx: captures ALU results on their done strobe, queues them in a small FIFO
// and feeds them one byte at a time to the UART transmitter using a start/done handshake.
// Up to FIFO_DEPTH bytes can wait while one more is in flight; anything beyond that is
// dropped and flagged with a one-cycle overflow pulse.
module interfaz_tx #(
    parameter int NB_DATA    = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int NB_PTR     = 2
) (
    input logic         i_clk,
    input logic         i_rst,
    interfaz_tx_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [NB_PTR:0] FULL_COUNT = (NB_PTR + 1)'(FIFO_DEPTH);

    state_t             state;
    logic [NB_DATA-1:0] mem [FIFO_DEPTH];
    logic [NB_PTR-1:0]  wr_ptr;
    logic [NB_PTR-1:0]  rd_ptr;
    logic [NB_PTR:0]    count;
    logic               push;
    logic               pop;
    logic               tx_start;
    logic [NB_DATA-1:0] tx_data;
    logic               overflow;

    // A result is stored only if the FIFO had room before this edge; a same-edge pop
    // does not make room for it.
    assign push = bus.i_alu_valid && (count != FULL_COUNT);

    // The sender pulls the head whenever it is idle and something is queued.
    assign pop = (state == IDLE) && (count != '0);

    // Storage array write port.
    // NOTE: the array has no reset; count/pointers define which entries are live, so stale contents are never read.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.i_resultado;
        end
    end

    // FIFO bookkeeping plus the IDLE/START/WAIT sender, all outputs registered.
    // NOTE: every assignment here is non-blocking so all decisions use pre-edge state and count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= bus.i_alu_valid && (count == FULL_COUNT);

            // Pointers wrap naturally because FIFO_DEPTH is a power of two.
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            // Simultaneous push and pop leave the count unchanged.
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            case (state)
                IDLE: begin
                    tx_start <= 1'b0;
                    if (pop) begin
                        tx_data  <= mem[rd_ptr];
                        tx_start <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    // The UART cannot finish within one cycle, so done is not looked at here.
                    tx_start <= 1'b0;
                    state    <= WAIT;
                end
                WAIT: begin
                    tx_start <= 1'b0;
                    if (bus.i_tx_done) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    tx_start <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_tx_start = tx_start;
    assign bus.o_tx_data  = tx_data;
    assign bus.o_overflow = overflow;
    assign bus.o_busy     = (state != IDLE) || (count != '0);
    assign bus.o_full     = (count == FULL_COUNT);

endmodule
